// File: rtl/punc_control_fsm_pkg.sv
// Shared definitions for the PUnC control unit and datapath.
// Contents: LC3 opcode constants, FSM state encoding, and the encodings of
// every datapath select line that the controller drives.
package punc_control_fsm_pkg;

  // LC3 opcodes (ir[15:12])
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  // FSM state encoding
  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_EXEC2  = 3'd4;
  localparam logic [2:0] ST_EXEC3  = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // Memory address source
  localparam logic [1:0] ADDR_PC  = 2'b00;
  localparam logic [1:0] ADDR_ALU = 2'b01;
  localparam logic [1:0] ADDR_ST  = 2'b10;

  // Register-file write data source
  localparam logic [1:0] WRF_PC  = 2'b00;
  localparam logic [1:0] WRF_MEM = 2'b01;
  localparam logic [1:0] WRF_ALU = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  // Single-bit selects
  localparam logic PCD_ADDER = 1'b0;  // PC load data from PC+offset adder
  localparam logic PCD_ALU   = 1'b1;  // PC load data from ALU
  localparam logic PCA_OFF11 = 1'b0;  // PC adder offset = sext(ir[10:0])
  localparam logic PCA_OFF9  = 1'b1;  // PC adder offset = sext(ir[8:0])
  localparam logic A_PC      = 1'b0;
  localparam logic A_RF      = 1'b1;
  localparam logic B_RF      = 1'b0;
  localparam logic B_SEXT    = 1'b1;
  localparam logic NZP_ALU   = 1'b0;
  localparam logic NZP_RF    = 1'b1;

endpackage

// File: rtl/punc_control_fsm_imm_sext.sv
// punc_imm_sext: picks the ALU-B immediate for the current instruction.
//   ir        in  16  current instruction
//   sext_imm  out 16  sext5 for ADD/AND, sext6 for LDR/STR, sext9 otherwise
module punc_imm_sext
  import punc_control_fsm_pkg::*;
(
  input  logic [15:0] ir,
  output logic [15:0] sext_imm
);

  logic [15:0] sext5;
  logic [15:0] sext6;
  logic [15:0] sext9;

  assign sext5 = {{11{ir[4]}}, ir[4:0]};
  assign sext6 = {{10{ir[5]}}, ir[5:0]};
  assign sext9 = {{7{ir[8]}},  ir[8:0]};

  always_comb begin
    case (ir[15:12])
      OP_ADD, OP_AND: sext_imm = sext5;
      OP_LDR, OP_STR: sext_imm = sext6;
      default:        sext_imm = sext9;
    endcase
  end

endmodule

// File: rtl/punc_control_fsm.sv
// punc_control_fsm: LC3 control unit for the PUnC datapath.
// Sequences INIT -> FETCH -> DECODE -> EXEC [-> EXEC2 [-> EXEC3]] and parks in
// HALT on TRAP. All outputs are combinational from the state register and ir.
//   clk, rst          clock / asynchronous active-high reset
//   ir, n, z, p       instruction and condition flags from the datapath
//   PC_*, IR_ld       program counter / instruction register controls
//   addr_MEM_sel, w_en_MEM                  memory address select, write enable
//   w_RF_sel, w_addr_RF, w_en_RF, r_addr_*  register-file controls
//   sext_data, A_sel, B_sel, ALU_sel        ALU operand / op controls
//   NZP_sel, nzp_ld   condition-code source and load
//   halted            high while in HALT
module punc_control_fsm
  import punc_control_fsm_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        PC_ld,
  output logic        PC_data_sel,
  output logic        PC_add_sel,
  output logic        PC_clr,
  output logic        PC_inc,
  output logic        IR_ld,
  output logic [1:0]  addr_MEM_sel,
  output logic        w_en_MEM,
  output logic [1:0]  w_RF_sel,
  output logic [2:0]  w_addr_RF,
  output logic        w_en_RF,
  output logic [2:0]  r_addr_0_RF,
  output logic [2:0]  r_addr_1_RF,
  output logic [15:0] sext_data,
  output logic        A_sel,
  output logic        B_sel,
  output logic [1:0]  ALU_sel,
  output logic        NZP_sel,
  output logic        nzp_ld,
  output logic        halted
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [3:0]  opcode;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [15:0] sext_imm;
  logic        br_taken;

  assign opcode   = ir[15:12];
  assign dr       = ir[11:9];
  assign sr1      = ir[8:6];
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  punc_imm_sext u_imm_sext (
    .ir       (ir),
    .sext_imm (sext_imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (opcode == HALT_OPCODE)
          state_d = ST_HALT;
        else if (opcode == OP_LD || opcode == OP_LDR || opcode == OP_LDI)
          state_d = ST_EXEC2;
        else
          state_d = ST_FETCH;
      end
      ST_EXEC2:  state_d = (opcode == OP_LDI) ? ST_EXEC3 : ST_FETCH;
      ST_EXEC3:  state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_INIT;
    endcase
  end

  always_comb begin
    PC_ld        = 1'b0;
    PC_data_sel  = PCD_ADDER;
    PC_add_sel   = PCA_OFF11;
    PC_clr       = 1'b0;
    PC_inc       = 1'b0;
    IR_ld        = 1'b0;
    addr_MEM_sel = ADDR_PC;
    w_en_MEM     = 1'b0;
    w_RF_sel     = WRF_PC;
    w_addr_RF    = 3'd0;
    w_en_RF      = 1'b0;
    r_addr_0_RF  = 3'd0;
    r_addr_1_RF  = 3'd0;
    sext_data    = 16'd0;
    A_sel        = A_PC;
    B_sel        = B_RF;
    ALU_sel      = ALU_ADD;
    NZP_sel      = NZP_ALU;
    nzp_ld       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_INIT:  PC_clr = 1'b1;
      ST_FETCH: IR_ld  = 1'b1;
      // Second IR load re-reads the same word while PC advances, so ir is
      // stable and valid for the whole of EXEC.
      ST_DECODE: begin
        IR_ld  = 1'b1;
        PC_inc = 1'b1;
      end
      ST_EXEC: begin
        if (opcode != HALT_OPCODE) begin
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              A_sel       = A_RF;
              r_addr_0_RF = sr1;
              if (opcode == OP_NOT) begin
                ALU_sel = ALU_NOT;
              end else begin
                ALU_sel = (opcode == OP_AND) ? ALU_AND : ALU_ADD;
                if (ir[5]) begin
                  B_sel     = B_SEXT;
                  sext_data = sext_imm;
                end else begin
                  r_addr_1_RF = ir[2:0];
                end
              end
              w_RF_sel  = WRF_ALU;
              w_addr_RF = dr;
              w_en_RF   = 1'b1;
              nzp_ld    = 1'b1;
            end
            OP_BR: begin
              PC_ld      = br_taken;
              PC_add_sel = br_taken ? PCA_OFF9 : PCA_OFF11;
            end
            OP_JMP: begin
              A_sel       = A_RF;
              r_addr_0_RF = sr1;
              ALU_sel     = ALU_PASS;
              PC_ld       = 1'b1;
              PC_data_sel = PCD_ALU;
            end
            // R7 captures the incremented PC in the same cycle the PC is
            // loaded, so JSRR R7 still sees the old R7 on the read port.
            OP_JSR: begin
              w_RF_sel  = WRF_PC;
              w_addr_RF = 3'd7;
              w_en_RF   = 1'b1;
              PC_ld     = 1'b1;
              if (!ir[11]) begin
                A_sel       = A_RF;
                r_addr_0_RF = sr1;
                ALU_sel     = ALU_PASS;
                PC_data_sel = PCD_ALU;
              end
            end
            OP_LEA: begin
              B_sel     = B_SEXT;
              sext_data = sext_imm;
              w_RF_sel  = WRF_ALU;
              w_addr_RF = dr;
              w_en_RF   = 1'b1;
              nzp_ld    = 1'b1;
            end
            // Loads and stores compute their address on the ALU:
            // PC + sext9 for LD/ST/LDI, RF[sr1] + sext6 for LDR/STR.
            OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR: begin
              B_sel        = B_SEXT;
              sext_data    = sext_imm;
              addr_MEM_sel = ADDR_ALU;
              if (opcode == OP_LDR || opcode == OP_STR) begin
                A_sel       = A_RF;
                r_addr_0_RF = sr1;
              end
              if (opcode == OP_ST || opcode == OP_STR) begin
                r_addr_1_RF = dr;
                w_en_MEM    = 1'b1;
              end else begin
                w_RF_sel  = WRF_MEM;
                w_addr_RF = dr;
                w_en_RF   = 1'b1;
              end
            end
            default: ;  // STI, RTI, reserved: no operation
          endcase
        end
      end
      ST_EXEC2: begin
        r_addr_0_RF = dr;
        if (opcode == OP_LDI) begin
          // Indirect step: the pointer just loaded into DR addresses memory.
          A_sel        = A_RF;
          ALU_sel      = ALU_PASS;
          addr_MEM_sel = ADDR_ALU;
          w_RF_sel     = WRF_MEM;
          w_addr_RF    = dr;
          w_en_RF      = 1'b1;
        end else begin
          NZP_sel = NZP_RF;
          nzp_ld  = 1'b1;
        end
      end
      ST_EXEC3: begin
        r_addr_0_RF = dr;
        NZP_sel     = NZP_RF;
        nzp_ld      = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_punc_control_fsm.sv
module tb_punc_control_fsm;

  typedef struct packed {
    logic        pc_ld;
    logic        pc_data_sel;
    logic        pc_add_sel;
    logic        pc_clr;
    logic        pc_inc;
    logic        ir_ld;
    logic [1:0]  addr_mem_sel;
    logic        w_en_mem;
    logic [1:0]  w_rf_sel;
    logic [2:0]  w_addr_rf;
    logic        w_en_rf;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [15:0] sext;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  alu_sel;
    logic        nzp_sel;
    logic        nzp_ld;
    logic        halted;
  } ctl_t;

  logic        clk;
  logic        rst;
  logic [15:0] ir;
  logic        n, z, p;
  logic        PC_ld, PC_data_sel, PC_add_sel, PC_clr, PC_inc, IR_ld;
  logic [1:0]  addr_MEM_sel;
  logic        w_en_MEM;
  logic [1:0]  w_RF_sel;
  logic [2:0]  w_addr_RF;
  logic        w_en_RF;
  logic [2:0]  r_addr_0_RF, r_addr_1_RF;
  logic [15:0] sext_data;
  logic        A_sel, B_sel;
  logic [1:0]  ALU_sel;
  logic        NZP_sel, nzp_ld, halted;

  int checks;
  int failures;
  ctl_t  exp_q[$];
  string name_q[$];

  punc_control_fsm dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .PC_ld(PC_ld), .PC_data_sel(PC_data_sel), .PC_add_sel(PC_add_sel),
    .PC_clr(PC_clr), .PC_inc(PC_inc), .IR_ld(IR_ld),
    .addr_MEM_sel(addr_MEM_sel), .w_en_MEM(w_en_MEM),
    .w_RF_sel(w_RF_sel), .w_addr_RF(w_addr_RF), .w_en_RF(w_en_RF),
    .r_addr_0_RF(r_addr_0_RF), .r_addr_1_RF(r_addr_1_RF),
    .sext_data(sext_data), .A_sel(A_sel), .B_sel(B_sel), .ALU_sel(ALU_sel),
    .NZP_sel(NZP_sel), .nzp_ld(nzp_ld), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One stimulus cycle: drive inputs just after the edge and queue the
  // hand-computed output vector for that cycle.
  task automatic cyc(input logic rst_v, input logic [15:0] ir_v,
                     input logic [2:0] nzp_v, input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    rst = rst_v;
    ir  = ir_v;
    {n, z, p} = nzp_v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  ctl_t e_zero, e_init, e_fetch, e_decode, e_halt;

  task automatic instr(input logic [15:0] ir_v, input logic [2:0] nzp_v,
                       input ctl_t e, input string nm);
    cyc(1'b0, ir_v, nzp_v, e_fetch, "fetch");
    cyc(1'b0, ir_v, nzp_v, e_decode, "decode");
    cyc(1'b0, ir_v, nzp_v, e, nm);
  endtask

  // Monitor: every cycle is a DUT output; compare on the falling edge.
  ctl_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = '{PC_ld, PC_data_sel, PC_add_sel, PC_clr, PC_inc, IR_ld,
              addr_MEM_sel, w_en_MEM, w_RF_sel, w_addr_RF, w_en_RF,
              r_addr_0_RF, r_addr_1_RF, sext_data, A_sel, B_sel, ALU_sel,
              NZP_sel, nzp_ld, halted};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", nm, got, e);
      end else begin
        $display("ok   %s ctl=%h", nm, got);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ir = 16'h0000;
    {n, z, p} = 3'b000;

    e_zero = '0;
    e_init = '0;   e_init.pc_clr = 1'b1;
    e_fetch = '0;  e_fetch.ir_ld = 1'b1;
    e_decode = '0; e_decode.ir_ld = 1'b1; e_decode.pc_inc = 1'b1;
    e_halt = '0;   e_halt.halted = 1'b1;

    // Reset held two cycles, then one INIT cycle after release
    cyc(1'b1, 16'h0000, 3'b000, e_init, "reset0");
    cyc(1'b1, 16'h0000, 3'b000, e_init, "reset1");
    cyc(1'b0, 16'h1265, 3'b000, e_init, "init");

    // ADD R1,R1,#5
    e = '0; e.a_sel = 1; e.r0 = 3'd1; e.b_sel = 1; e.sext = 16'd5;
    e.w_rf_sel = 2'b10; e.w_addr_rf = 3'd1; e.w_en_rf = 1; e.nzp_ld = 1;
    instr(16'h1265, 3'b000, e, "add_imm");

    // AND R5,R1,R2
    e = '0; e.a_sel = 1; e.r0 = 3'd1; e.r1 = 3'd2; e.alu_sel = 2'b01;
    e.w_rf_sel = 2'b10; e.w_addr_rf = 3'd5; e.w_en_rf = 1; e.nzp_ld = 1;
    instr(16'h5A42, 3'b000, e, "and_reg");

    // NOT R5,R1
    e = '0; e.a_sel = 1; e.r0 = 3'd1; e.alu_sel = 2'b11;
    e.w_rf_sel = 2'b10; e.w_addr_rf = 3'd5; e.w_en_rf = 1; e.nzp_ld = 1;
    instr(16'h9A7F, 3'b000, e, "not");

    // BRz +2 taken on z, not taken on n
    e = '0; e.pc_ld = 1; e.pc_add_sel = 1;
    instr(16'h0402, 3'b010, e, "brz_taken");
    instr(16'h0402, 3'b100, e_zero, "brz_not_taken");

    // LDI R1 : EXEC, EXEC2, EXEC3
    instr(16'hA205, 3'b000, '{pc_ld:0, pc_data_sel:0, pc_add_sel:0, pc_clr:0,
          pc_inc:0, ir_ld:0, addr_mem_sel:2'b01, w_en_mem:0, w_rf_sel:2'b01,
          w_addr_rf:3'd1, w_en_rf:1, r0:3'd0, r1:3'd0, sext:16'd5, a_sel:0,
          b_sel:1, alu_sel:2'b00, nzp_sel:0, nzp_ld:0, halted:0}, "ldi_exec");
    e = '0; e.r0 = 3'd1; e.a_sel = 1; e.alu_sel = 2'b10; e.addr_mem_sel = 2'b01;
    e.w_rf_sel = 2'b01; e.w_addr_rf = 3'd1; e.w_en_rf = 1;
    cyc(1'b0, 16'hA205, 3'b000, e, "ldi_exec2");
    e = '0; e.r0 = 3'd1; e.nzp_sel = 1; e.nzp_ld = 1;
    cyc(1'b0, 16'hA205, 3'b000, e, "ldi_exec3");

    // LDR R3,R2,#-2 : EXEC, EXEC2
    e = '0; e.a_sel = 1; e.r0 = 3'd2; e.b_sel = 1; e.sext = 16'hFFFE;
    e.addr_mem_sel = 2'b01; e.w_rf_sel = 2'b01; e.w_addr_rf = 3'd3; e.w_en_rf = 1;
    instr(16'h66BE, 3'b000, e, "ldr_exec");
    e = '0; e.r0 = 3'd3; e.nzp_sel = 1; e.nzp_ld = 1;
    cyc(1'b0, 16'h66BE, 3'b000, e, "ldr_exec2");

    // STR R4,R2,#3
    e = '0; e.a_sel = 1; e.r0 = 3'd2; e.r1 = 3'd4; e.b_sel = 1; e.sext = 16'd3;
    e.addr_mem_sel = 2'b01; e.w_en_mem = 1;
    instr(16'h7883, 3'b000, e, "str");

    // JSR +3
    e = '0; e.w_addr_rf = 3'd7; e.w_en_rf = 1; e.pc_ld = 1;
    instr(16'h4803, 3'b000, e, "jsr");

    // JSRR R3
    e = '0; e.w_addr_rf = 3'd7; e.w_en_rf = 1; e.pc_ld = 1; e.pc_data_sel = 1;
    e.a_sel = 1; e.r0 = 3'd3; e.alu_sel = 2'b10;
    instr(16'h40C0, 3'b000, e, "jsrr");

    // RET (JMP R7)
    e = '0; e.r0 = 3'd7; e.a_sel = 1; e.alu_sel = 2'b10; e.pc_ld = 1; e.pc_data_sel = 1;
    instr(16'hC1C0, 3'b000, e, "ret");

    // LEA R0,#-1
    e = '0; e.b_sel = 1; e.sext = 16'hFFFF; e.w_rf_sel = 2'b10;
    e.w_en_rf = 1; e.nzp_ld = 1;
    instr(16'hE1FF, 3'b000, e, "lea");

    // RTI is a NOP
    instr(16'h8000, 3'b111, e_zero, "rti_nop");

    // TRAP -> HALT, sticky for 20 cycles
    instr(16'hF025, 3'b000, e_zero, "trap");
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'hF025, 3'b000, e_halt, "halt");

    // Asynchronous reset mid-cycle: INIT before the next rising edge
    cyc(1'b1, 16'hF025, 3'b000, e_init, "async_rst");
    cyc(1'b1, 16'hF025, 3'b000, e_init, "rst_hold");
    cyc(1'b0, 16'h1265, 3'b000, e_init, "init_after");
    cyc(1'b0, 16'h1265, 3'b000, e_fetch, "fetch_after");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
